axi_attenuator_mc: RTL

Multi-channel successor to the single-channel AXI attenuator controller.
- AXI4-Lite slave holding N_CH attenuation words.
- Serialises each updated word onto a shared SI/CLK bus, with a per-channel latch-enable strobe, for step-attenuator chips.
- Serial clock and settle timing are derived from the single AXI clock, so no separate attenuator or timer clock is needed.

---
 rtl/att_mc_pkg.sv | 21 ++
 rtl/att_serial_engine.sv | 124 ++++++++++++
 rtl/axi_attenuator_mc.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/att_mc_pkg.sv
// Shared definitions for the multi-channel attenuator controller: register
// offsets, CTRL/STATUS bit positions and the serial engine state type.
package att_mc_pkg;

    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_CTRL    = 8'h04;
    localparam logic [7:0] ADDR_CH_BASE = 8'h10;

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_FLUSH_BIT  = 1;
    localparam int STATUS_PEND_LSB = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH,
        SETTLE
    } att_state_t;

endpackage

// File: rtl/att_serial_engine.sv
// Serial engine: shifts one word LSB first on att_clk/att_si, pulses the
// selected latch enable, then holds off for the settle time.
//
// state  | meaning
// IDLE   | waiting for start_i
// LOAD   | snapshot word_i into the shift register
// SHIFT  | WORD_W clock periods, low phase first, data changes on falling edge
// LATCH  | att_le[ch] high for LE_CYCLES, clock and data held low
// SETTLE | idle for SETTLE_CYCLES before the next channel may start
module att_serial_engine
    import att_mc_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int WORD_W        = 16,
    parameter int CLK_DIV       = 5,
    parameter int LE_CYCLES     = 5,
    parameter int SETTLE_CYCLES = 4000,
    parameter int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [CH_W-1:0]   ch_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              att_clk_o,
    output logic              att_si_o,
    output logic [N_CH-1:0]   att_le_o
);

    localparam int DIV_W   = $clog2(CLK_DIV + 1);
    localparam int BIT_W   = $clog2(WORD_W + 1);
    localparam int CNT_MAX = (LE_CYCLES > SETTLE_CYCLES) ? LE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    att_state_t        state_q;
    logic [DIV_W-1:0]  div_q;
    logic [BIT_W-1:0]  bit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] sr_q;
    logic [CH_W-1:0]   ch_q;
    logic              clk_q;
    logic              done_q;
    logic [N_CH-1:0]   le_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
            ch_q    <= '0;
            clk_q   <= 1'b0;
            done_q  <= 1'b0;
            le_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        ch_q    <= ch_i;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    sr_q    <= word_i;
                    bit_q   <= '0;
                    clk_q   <= 1'b0;
                    div_q   <= DIV_W'(CLK_DIV - 1);
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (div_q != '0) begin
                        div_q <= div_q - 1'b1;
                    end else begin
                        div_q <= DIV_W'(CLK_DIV - 1);
                        if (!clk_q) begin
                            clk_q <= 1'b1;
                        end else begin
                            clk_q <= 1'b0;
                            if (bit_q == BIT_W'(WORD_W - 1)) begin
                                sr_q    <= '0;
                                le_q    <= N_CH'(1) << ch_q;
                                cnt_q   <= CNT_W'(LE_CYCLES - 1);
                                state_q <= LATCH;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                                sr_q  <= sr_q >> 1;
                            end
                        end
                    end
                end
                LATCH: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        le_q    <= '0;
                        cnt_q   <= CNT_W'(SETTLE_CYCLES - 1);
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // sr_q is cleared outside SHIFT, so its LSB doubles as the idle-low data pin
    assign att_si_o  = sr_q[0];
    assign att_clk_o = clk_q;
    assign att_le_o  = le_q;
    assign done_o    = done_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: rtl/axi_attenuator_mc.sv
// AXI4-Lite multi-channel attenuator controller: register file, pending mask
// and round-robin arbiter. Define ATT_SHADOW_EN for shadowed channel writes.
module axi_attenuator_mc
    import att_mc_pkg::*;
#(
    parameter int N_CH               = 4,
    parameter int WORD_W             = 16,
    parameter int CLK_DIV            = 5,
    parameter int LE_CYCLES          = 5,
    parameter int SETTLE_CYCLES      = 4000,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                          s00_axi_aclk,
    input  logic                          s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
    input  logic [2:0]                    s00_axi_awprot,
    input  logic                          s00_axi_awvalid,
    output logic                          s00_axi_awready,
    input  logic [31:0]                   s00_axi_wdata,
    input  logic [3:0]                    s00_axi_wstrb,
    input  logic                          s00_axi_wvalid,
    output logic                          s00_axi_wready,
    output logic [1:0]                    s00_axi_bresp,
    output logic                          s00_axi_bvalid,
    input  logic                          s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
    input  logic [2:0]                    s00_axi_arprot,
    input  logic                          s00_axi_arvalid,
    output logic                          s00_axi_arready,
    output logic [31:0]                   s00_axi_rdata,
    output logic [1:0]                    s00_axi_rresp,
    output logic                          s00_axi_rvalid,
    input  logic                          s00_axi_rready,
    output logic                          att_clk,
    output logic                          att_si,
    output logic [N_CH-1:0]               att_le,
    output logic                          busy
);

    localparam int AW   = C_S_AXI_ADDR_WIDTH;
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic              awready_q, arready_q, bvalid_q, rvalid_q;
    logic [31:0]       rdata_q, rd_mux;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [CH_W-1:0]   last_q, sel, w_ch, r_ch;
    logic [WORD_W-1:0] act_q [N_CH];
`ifdef ATT_SHADOW_EN
    logic [WORD_W-1:0] shd_q [N_CH];
    logic              commit;
`endif
    logic [AW-1:0]     w_word, r_word;
    logic              w_is_ch, r_is_ch, w_is_ctrl, do_wr, do_rd, flush, start;
    logic              eng_busy, eng_done;
    logic [31:0]       wmask;
    logic [WORD_W-1:0] wmask_w;
    logic              unused_ok;

    assign do_wr     = awready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign do_rd     = arready_q & s00_axi_arvalid;
    assign w_word    = {s00_axi_awaddr[AW-1:2], 2'b00};
    assign r_word    = {s00_axi_araddr[AW-1:2], 2'b00};
    assign w_is_ctrl = (w_word == AW'(ADDR_CTRL));
    assign w_is_ch   = (w_word >= AW'(ADDR_CH_BASE)) && (w_word < AW'(ADDR_CH_BASE + 4 * N_CH));
    assign r_is_ch   = (r_word >= AW'(ADDR_CH_BASE)) && (r_word < AW'(ADDR_CH_BASE + 4 * N_CH));
    assign w_ch      = CH_W'((w_word - AW'(ADDR_CH_BASE)) >> 2);
    assign r_ch      = CH_W'((r_word - AW'(ADDR_CH_BASE)) >> 2);
    assign wmask     = {{8{s00_axi_wstrb[3]}}, {8{s00_axi_wstrb[2]}},
                        {8{s00_axi_wstrb[1]}}, {8{s00_axi_wstrb[0]}}};
    assign wmask_w   = wmask[WORD_W-1:0];
    assign flush     = do_wr & w_is_ctrl & s00_axi_wstrb[0] & s00_axi_wdata[CTRL_FLUSH_BIT];
`ifdef ATT_SHADOW_EN
    assign commit    = do_wr & w_is_ctrl & s00_axi_wstrb[0] & s00_axi_wdata[CTRL_COMMIT_BIT];
`endif
    assign start     = !eng_busy && (pend_q != '0);

    // Round-robin: first pending channel after the one served last
    always_comb begin
        int idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        sel   = last_q;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last_q) + i) % N_CH;
            if (!found && pend_q[idx]) begin
                sel   = CH_W'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (start) pend_d[sel] = 1'b0;
        if (flush) pend_d = '0;
`ifdef ATT_SHADOW_EN
        if (commit) begin
            for (int k = 0; k < N_CH; k++)
                if (shd_q[k] != act_q[k]) pend_d[k] = 1'b1;
        end
`else
        if (do_wr && w_is_ch && (wmask_w != '0)) pend_d[w_ch] = 1'b1;
`endif
    end

    always_comb begin
        rd_mux = '0;
        if (r_word == AW'(ADDR_STATUS)) begin
            rd_mux[0]                       = busy;
            rd_mux[STATUS_PEND_LSB +: N_CH] = pend_q;
        end else if (r_is_ch) begin
`ifdef ATT_SHADOW_EN
            rd_mux[WORD_W-1:0] = shd_q[r_ch];
`else
            rd_mux[WORD_W-1:0] = act_q[r_ch];
`endif
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            pend_q    <= '0;
            last_q    <= CH_W'(N_CH - 1);
            for (int k = 0; k < N_CH; k++) begin
                act_q[k] <= '0;
`ifdef ATT_SHADOW_EN
                shd_q[k] <= '0;
`endif
            end
        end else begin
            awready_q <= s00_axi_awvalid && s00_axi_wvalid && !bvalid_q && !awready_q;
            arready_q <= s00_axi_arvalid && !rvalid_q && !arready_q;
            if (bvalid_q && s00_axi_bready) bvalid_q <= 1'b0;
            if (do_wr) bvalid_q <= 1'b1;
            if (rvalid_q && s00_axi_rready) rvalid_q <= 1'b0;
            if (do_rd) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end
            pend_q <= pend_d;
            if (start) last_q <= sel;
            for (int k = 0; k < N_CH; k++) begin
`ifdef ATT_SHADOW_EN
                if (do_wr && w_is_ch && w_ch == CH_W'(k))
                    shd_q[k] <= (shd_q[k] & ~wmask_w) | (s00_axi_wdata[WORD_W-1:0] & wmask_w);
                if (commit) act_q[k] <= shd_q[k];
`else
                if (do_wr && w_is_ch && w_ch == CH_W'(k))
                    act_q[k] <= (act_q[k] & ~wmask_w) | (s00_axi_wdata[WORD_W-1:0] & wmask_w);
`endif
            end
        end
    end

    att_serial_engine #(
        .N_CH          (N_CH),
        .WORD_W        (WORD_W),
        .CLK_DIV       (CLK_DIV),
        .LE_CYCLES     (LE_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CH_W          (CH_W)
    ) u_engine (
        .clk_i     (s00_axi_aclk),
        .rst_ni    (s00_axi_aresetn),
        .start_i   (start),
        .ch_i      (sel),
        .word_i    (act_q[last_q]),
        .busy_o    (eng_busy),
        .done_o    (eng_done),
        .att_clk_o (att_clk),
        .att_si_o  (att_si),
        .att_le_o  (att_le)
    );

    assign busy            = eng_busy | (pend_q != '0);
    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = awready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign unused_ok       = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                               s00_axi_araddr[1:0], s00_axi_wdata, eng_done};

endmodule
